// File: rtl/alu_result_buffer.sv
// Result buffer behind the 64-bit logic unit: captures {result, select, flags}
// through a valid/ready handshake, queues them, and presents them show-ahead.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [63:0]             in_res,
  input  logic [2:0]              in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_res,
  output logic [2:0]              out_sel,
  output logic                    out_zero,
  output logic                    out_ones,
  output logic                    out_parity,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [CNT_W-1:0]        done_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  typedef struct packed {
    logic [63:0] res;
    logic [2:0]  sel;
    logic        zero;
    logic        ones;
    logic        parity;
  } entry_t;

  localparam entry_t RESET_HEAD = '{res: 64'h0, sel: 3'h0, zero: 1'b1, ones: 1'b0, parity: 1'b0};

  entry_t        mem [DEPTH];
  entry_t        head_q;
  entry_t        head_nxt;
  entry_t        new_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_nxt;
  logic [OW-1:0] occ_nxt;
  logic          push_c;
  logic          pop_c;

  assign push_c = in_valid && in_ready;
  assign pop_c  = out_valid && out_ready;

  // Flags are computed once at capture and stored alongside the result.
  always_comb begin
    new_entry.res    = in_res;
    new_entry.sel    = in_sel;
    new_entry.zero   = ~|in_res;
    new_entry.ones   = &in_res;
    new_entry.parity = ^in_res;
  end

  // Next pointers, occupancy and the head entry to present next cycle.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    occ_nxt    = occupancy;
    head_nxt   = head_q;
    if (push_c) wr_ptr_nxt = wr_ptr + AW'(1);
    if (pop_c)  rd_ptr_nxt = rd_ptr + AW'(1);
    case ({push_c, pop_c})
      2'b10:   occ_nxt = occupancy + OW'(1);
      2'b01:   occ_nxt = occupancy - OW'(1);
      default: occ_nxt = occupancy;
    endcase
    // The slot being written this cycle becomes head only when it is the sole entry.
    if (occ_nxt != '0) begin
      if (push_c && (wr_ptr == rd_ptr_nxt)) head_nxt = new_entry;
      else                                   head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      done_count <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      head_q     <= RESET_HEAD;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      occupancy  <= occ_nxt;
      in_ready   <= (occ_nxt != OW'(DEPTH));
      out_valid  <= (occ_nxt != '0);
      head_q     <= head_nxt;
      if (pop_c) done_count <= done_count + CNT_W'(1);
    end
  end

  // Storage array carries no reset; occupancy qualifies its contents.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= new_entry;
  end

  assign out_res    = head_q.res;
  assign out_sel    = head_q.sel;
  assign out_zero   = head_q.zero;
  assign out_ones   = head_q.ones;
  assign out_parity = head_q.parity;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: flag table, latency, full,
// streaming, random soak and asynchronous reset, all against a scoreboard queue.
module tb_alu_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [63:0]            in_res;
  logic [2:0]             in_sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [63:0]            out_res;
  logic [2:0]             out_sel;
  logic                   out_zero;
  logic                   out_ones;
  logic                   out_parity;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]       done_count;

  alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_sel(out_sel),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
    .occupancy(occupancy), .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  sel;
  } item_t;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  sel;
    logic        zero;
    logic        ones;
    logic        parity;
  } vec_t;

  item_t            sb[$];
  logic [CNT_W-1:0] cnt_m;
  int               tests;
  int               fails;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare DUT state to the model, then advance one clock and update the model.
  task automatic tick();
    logic push, pop;
    int   n;
    n = sb.size();
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
    chk("occupancy", 64'(occupancy), 64'(n));
    chk("done_count", 64'(done_count), 64'(cnt_m));
    if (n != 0) begin
      chk("head_res", out_res, sb[0].res);
      chk("head_sel", 64'(out_sel), 64'(sb[0].sel));
      chk("head_zero", 64'(out_zero), 64'(sb[0].res == 64'h0));
      chk("head_ones", 64'(out_ones), 64'(sb[0].res == {64{1'b1}}));
      chk("head_parity", 64'(out_parity), 64'($countones(sb[0].res) % 2));
    end
    push = in_valid && (n != DEPTH);
    pop  = out_ready && (n != 0);
    @(posedge clk);
    if (pop) begin
      void'(sb.pop_front());
      cnt_m = cnt_m + CNT_W'(1);
    end
    if (push) sb.push_back('{res: in_res, sel: in_sel});
    #1;
  endtask

  vec_t vecs [5];

  initial begin
    tests = 0; fails = 0; cnt_m = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_res = '0; in_sel = '0;

    vecs[0] = '{res: 64'h0000_0000_0000_0007, sel: 3'd3, zero: 1'b0, ones: 1'b0, parity: 1'b1};
    vecs[1] = '{res: 64'h0000_0000_0000_0000, sel: 3'd0, zero: 1'b1, ones: 1'b0, parity: 1'b0};
    vecs[2] = '{res: 64'hFFFF_FFFF_FFFF_FFFF, sel: 3'd5, zero: 1'b0, ones: 1'b1, parity: 1'b0};
    vecs[3] = '{res: 64'h8000_0000_0000_0001, sel: 3'd7, zero: 1'b0, ones: 1'b0, parity: 1'b0};
    vecs[4] = '{res: 64'h0000_0000_0000_0100, sel: 3'd1, zero: 1'b0, ones: 1'b0, parity: 1'b1};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd1);
    chk("rst_out_res", out_res, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_occupancy", 64'(occupancy), 64'd0);
    chk("idle_done_count", 64'(done_count), 64'd0);
    chk("idle_out_zero", 64'(out_zero), 64'd1);

    // Single transfer and one-cycle latency
    in_valid = 1'b1; in_res = 64'h7; in_sel = 3'b011;
    chk("lat_out_valid_before", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_res", out_res, 64'h7);
    chk("lat_out_sel", 64'(out_sel), 64'd3);
    chk("lat_flags", 64'({out_zero, out_ones, out_parity}), 64'b001);
    chk("lat_occupancy", 64'(occupancy), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_out_valid", 64'(out_valid), 64'd0);
    chk("pop_done_count", 64'(done_count), 64'd1);

    // Flag table: push in groups of up to DEPTH, then drain checking each head
    for (int base = 0; base < 5; base += DEPTH) begin
      for (int i = base; i < base + DEPTH && i < 5; i++) begin
        in_valid = 1'b1; in_res = vecs[i].res; in_sel = vecs[i].sel;
        tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = base; i < base + DEPTH && i < 5; i++) begin
        chk($sformatf("vec%0d_res", i), out_res, vecs[i].res);
        chk($sformatf("vec%0d_sel", i), 64'(out_sel), 64'(vecs[i].sel));
        chk($sformatf("vec%0d_flags", i), 64'({out_zero, out_ones, out_parity}),
            64'({vecs[i].zero, vecs[i].ones, vecs[i].parity}));
        tick();
      end
      out_ready = 1'b0;
    end

    // Full and backpressure: 5 offered, 4 stored
    for (int v = 1; v <= 5; v++) begin
      in_valid = 1'b1; in_res = 64'(v); in_sel = 3'(v);
      tick();
      if (v == 4) begin
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_occupancy", 64'(occupancy), 64'd4);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk("full_order", out_res, 64'(v));
      tick();
    end
    out_ready = 1'b0;
    chk("full_drained_occ", 64'(occupancy), 64'd0);
    chk("full_fifth_dropped", 64'(out_valid), 64'd0);

    // Streaming across the pointer wrap
    begin
      logic [CNT_W-1:0] d0;
      d0 = done_count;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int v = 10; v <= 19; v++) begin
        in_res = 64'(v); in_sel = 3'(v);
        tick();
        if (occupancy > 1) chk("stream_occ_le1", 64'(occupancy), 64'd1);
        chk("stream_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      chk("stream_done_count", 64'(done_count - d0), 64'd10);
    end

    // Random stall soak
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_res    = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) in_res = '0;
      if ($urandom_range(0, 7) == 0) in_res = '1;
      in_sel    = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < DEPTH + 1; c++) tick();
    chk("soak_empty", 64'(occupancy), 64'd0);

    // Asynchronous reset in the middle of a cycle with entries buffered
    out_ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1; in_res = 64'hA0 + 64'(v); in_sel = 3'(v);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_occ", 64'(occupancy), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_done_count", 64'(done_count), 64'd0);
    chk("arst_out_res", out_res, 64'd0);
    chk("arst_out_zero", 64'(out_zero), 64'd1);
    sb.delete();
    cnt_m = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 64-bit combinational logic unit: captures each result together with its 3-bit select code through a valid/ready handshake.
- Computes status flags (zero, all-ones, parity) at capture time and buffers results in a small FIFO.
- Presents the buffered results to the writeback/consumer side with a second valid/ready handshake.
- Decouples the combinational unit from consumer stalls and counts delivered results.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_res/in_sel hold a result to capture.
- in_ready  output  1  buffer can accept an entry this cycle.
- in_res  input  64  result from the logic unit.
- in_sel  input  3  select code that produced in_res.
- out_valid  output  1  head entry is presented.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_res  output  64  head result.
- out_sel  output  3  head select code.
- out_zero  output  1  head result == 64'h0.
- out_ones  output  1  head result == 64'hFFFF_FFFF_FFFF_FFFF.
- out_parity  output  1  XOR-reduction of the head result (1 = odd count of ones).
- occupancy  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- done_count  output  CNT_W  number of entries popped since reset.

Behaviour:
- Clock and reset: clk is the single clock. rst_n is asynchronous, active low. While rst_n=0, all state clears immediately.
- Reset values:
  - occupancy=0, done_count=0, read/write pointers=0.
  - out_valid=0, in_ready=0 while rst_n=0, in_ready=1 from the first edge after release.
  - out_res=0, out_sel=0, out_zero=1, out_ones=0, out_parity=0.
- Push: occurs on a rising edge when in_valid && in_ready.
  - Writes {in_res, in_sel, zero, ones, parity} at the write pointer. Flags are computed from in_res combinationally and stored.
  - Write pointer increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Pop: occurs on a rising edge when out_valid && out_ready.
  - Read pointer increments modulo DEPTH.
  - done_count increments, wrapping to 0 at 2^CNT_W.
- Outputs are show-ahead and registered:
  - out_* always reflect the entry at the read pointer.
  - out_valid = (occupancy != 0).
  - When occupancy==0, out_res, out_sel and flags hold their last values; consumers must qualify them with out_valid.
- Latency: a push into an empty buffer makes out_valid=1 on the following cycle. There is no combinational in-to-out path.
- in_ready = (occupancy != DEPTH). It depends only on registered state, never on out_ready, so there is no combinational ready path through the block.
- Full (occupancy==DEPTH):
  - in_ready=0; in_valid is ignored and no overwrite occurs.
  - A pop this cycle frees a slot that is visible next cycle.
- Empty (occupancy==0): out_valid=0; out_ready is ignored; done_count is unchanged.
- Simultaneous push and pop (0 < occupancy < DEPTH): both pointers advance and occupancy is unchanged.
- Pointer wrap-around must preserve FIFO order across the DEPTH boundary.
- Reset mid-operation: all buffered entries are discarded. No partial transfer is reported after rst_n rises.
- in_sel is carried verbatim; all 8 codes are legal. Flags are derived only from in_res, not from in_sel.
- Handshake rule: the upstream must hold in_res/in_sel stable while in_valid=1 and in_ready=0. The block does not check this.

Test Plan:
- Reset/idle: hold rst_n=0, then release with in_valid=0. Required: out_valid=0, in_ready=1, occupancy=0, done_count=0, out_zero=1. Asserting rst_n=0 mid-cycle clears the outputs without waiting for a clock edge.
- Single transfer and latency: push in_res=64'h0000_0000_0000_0007, in_sel=3'b011 with out_ready=0.
  - Next cycle: out_valid=1, out_res=64'h7, out_sel=3, out_zero=0, out_ones=0, out_parity=1, occupancy=1.
  - Then pulse out_ready for one cycle. Required: out_valid=0, done_count=1.
- Flag corners: push 64'h0, 64'hFFFF_FFFF_FFFF_FFFF and 64'h8000_0000_0000_0001, then drain. Required per head entry:
  - 64'h0: zero=1, ones=0, parity=0.
  - all-ones: zero=0, ones=1, parity=0.
  - 64'h8000_0000_0000_0001: zero=0, ones=0, parity=0.
- Full and backpressure: DEPTH=4, out_ready=0, push 5 values 1..5 on consecutive cycles.
  - Required: in_ready=0 after the 4th push; occupancy=4; the 5th value is not stored.
  - Drain. Required: the output order is 1,2,3,4.
- Streaming with wrap: keep in_valid=1 and out_ready=1 continuously for 10 pushes of values 10..19.
  - Required: one result per cycle after the first, occupancy never exceeds 1, output order 10..19, done_count=10.
- Random stall soak: random in_valid/out_ready at 50% for 1000 cycles, compared against a scoreboard queue.
  - Required: no loss, duplication or reordering; occupancy matches the scoreboard size every cycle; done_count equals the number of pops.
